inst_fetch_responder: RTL and testbench



---
 rtl/inst_fetch_responder_pkg.sv | 15 +
 rtl/fetch_watchdog.sv | 26 ++
 rtl/inst_fetch_responder.sv | 177 +++++++++++++++++
 tb/tb_inst_fetch_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder.
package inst_fetch_responder_pkg;

    localparam int          HALF_W = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        PF_LO,
        PF_HI
    } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Beat watchdog: counts consecutive waiting cycles and pulses expire on the last one.
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expire = waiting && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || !waiting || expire) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/inst_fetch_responder.sv
// Fetch responder: one-word demand buffer filled by two 16-bit beats on the backing bus.
// Optional next-word prefetch entry is enabled with INST_FETCH_PREFETCH_EN.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       instruction,
    output logic              inst_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [HALF_W-1:0] mem_rdata,
    output logic              fetch_err
);

    localparam int TAG_W = ADDR_W - 2;

    fetch_state_t      state;
    fetch_state_t      beat;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  fetch_tag;
    logic [TAG_W-1:0]  buf_tag;
    logic [31:0]       buf_data;
    logic [31:0]       word;
    logic [HALF_W-1:0] lo_half;
    logic              buf_valid;
    logic              buf_hit;
    logic              hit;
    logic              tag_match;
    logic              waiting;
    logic              expire;
    logic              unused_addr_bits;

    assign req_tag          = inst_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^inst_addr[1:0];
    assign buf_hit          = buf_valid && (req_tag == buf_tag);
    assign tag_match        = (req_tag == fetch_tag);
    assign word             = {mem_rdata, lo_half};
    assign waiting          = mem_req && !mem_ack;

`ifdef INST_FETCH_PREFETCH_EN
    logic [TAG_W-1:0] pf_tag;
    logic [31:0]      pf_data;
    logic             pf_valid;
    logic             pf_match;
    logic             pf_take;
    logic             demand_done;

    assign pf_match    = pf_valid && (req_tag == pf_tag);
    assign hit         = buf_hit || pf_match;
    assign demand_done = (beat == FETCH_HI) && mem_ack;
    assign pf_take     = pf_match && !buf_hit && !demand_done;

    // A demand miss on the word already being prefetched takes over the beats in flight.
    always_comb begin
        beat = state;
        if (!hit && tag_match && state == PF_LO) beat = FETCH_LO;
        if (!hit && tag_match && state == PF_HI) beat = FETCH_HI;
    end
`else
    assign hit  = buf_hit;
    assign beat = state;
`endif

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= NOP;
            inst_ready  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fetch_err   <= 1'b0;
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
            buf_data    <= NOP;
            fetch_tag   <= '0;
            lo_half     <= '0;
`ifdef INST_FETCH_PREFETCH_EN
            pf_valid    <= 1'b0;
            pf_tag      <= '0;
            pf_data     <= NOP;
`endif
        end else begin
            state      <= beat;
            inst_ready <= buf_hit;
            if (buf_hit) instruction <= buf_data;
`ifdef INST_FETCH_PREFETCH_EN
            if (pf_take) begin
                inst_ready  <= 1'b1;
                instruction <= pf_data;
                buf_tag     <= pf_tag;
                buf_data    <= pf_data;
                buf_valid   <= 1'b1;
                pf_valid    <= 1'b0;
            end
`endif
            if (expire) begin
                state       <= IDLE;
                mem_req     <= 1'b0;
                fetch_err   <= 1'b1;
                buf_valid   <= 1'b0;
                inst_ready  <= 1'b1;
                instruction <= NOP;
            end else begin
                case (beat)
                    IDLE: begin
                        if (!hit) begin
                            fetch_tag <= req_tag;
                            mem_req   <= 1'b1;
                            mem_addr  <= {req_tag, 2'b00};
                            state     <= FETCH_LO;
                        end
                    end
                    FETCH_LO: begin
                        if (mem_ack) begin
                            lo_half  <= mem_rdata;
                            mem_addr <= {fetch_tag, 2'b10};
                            state    <= FETCH_HI;
                        end
                    end
                    FETCH_HI: begin
                        if (mem_ack) begin
                            buf_valid  <= 1'b1;
                            buf_tag    <= fetch_tag;
                            buf_data   <= word;
                            inst_ready <= tag_match;
                            if (tag_match) instruction <= word;
`ifdef INST_FETCH_PREFETCH_EN
                            fetch_tag <= fetch_tag + TAG_W'(1);
                            mem_addr  <= {fetch_tag + TAG_W'(1), 2'b00};
                            pf_valid  <= 1'b0;
                            state     <= PF_LO;
`else
                            mem_req   <= 1'b0;
                            state     <= IDLE;
`endif
                        end
                    end
`ifdef INST_FETCH_PREFETCH_EN
                    PF_LO: begin
                        if (mem_ack) begin
                            lo_half  <= mem_rdata;
                            mem_addr <= {fetch_tag, 2'b10};
                            state    <= PF_HI;
                        end
                    end
                    PF_HI: begin
                        if (mem_ack) begin
                            pf_tag   <= fetch_tag;
                            pf_data  <= word;
                            pf_valid <= 1'b1;
                            mem_req  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: word-level reference model plus directed cases.
module tb_inst_fetch_responder;

    localparam int          ADDR_W = 32;
    localparam int          TMO    = 8;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr = '0;
    logic [31:0] instruction;
    logic        inst_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        fetch_err;

    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    int          wcnt;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    int          bad100 = 0;
    bit          model_on = 1'b1;
    bit          pred_ok = 1'b0;
    logic [31:0] beats[$];
    logic [31:0] cur_word;

    // reference model state
    bit          m_valid;
    logic [29:0] m_tag;
    logic [31:0] m_data;
    bit          f_active;
    bit          f_hi;
    logic [29:0] f_tag;
    int          f_wait;
    logic        e_ready;
    logic [31:0] e_instr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_err;
    bit          e_chk_instr;

    inst_fetch_responder #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr  (inst_addr),
        .instruction(instruction),
        .inst_ready (inst_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] tag);
        if (tag == 30'd0) return 32'h0050_0093;
        return {tag[15:0], ~tag[15:0]};
    endfunction

    assign cur_word  = mem_word(mem_addr[31:2]);
    assign mem_rdata = mem_addr[1] ? cur_word[31:16] : cur_word[15:0];
    assign mem_ack   = mem_req && ack_en && (wcnt == ack_delay);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Predict the outputs that follow the current cycle from word-level fetch rules.
    task automatic predict();
        logic [29:0] t;
        bit          hit;
        t = inst_addr[31:2];
        e_chk_instr = 1'b0;
        if (rst) begin
            m_valid = 0; f_active = 0; f_wait = 0;
            e_ready = 0; e_instr = NOP_W; e_req = 0; e_addr = '0; e_err = 0;
            e_chk_instr = 1'b1;
            return;
        end
        hit = m_valid && (t == m_tag);
        e_ready = hit;
        if (hit) e_instr = m_data;
        if (f_active) begin
            if (mem_ack) begin
                f_wait = 0;
                if (!f_hi) begin
                    f_hi   = 1;
                    e_addr = {f_tag, 2'b10};
                end else begin
                    m_valid  = 1;
                    m_tag    = f_tag;
                    m_data   = mem_word(f_tag);
                    e_ready  = (t == f_tag);
                    if (e_ready) e_instr = m_data;
                    f_active = 0;
                    e_req    = 0;
                end
            end else begin
                f_wait++;
                if (f_wait == TMO) begin
                    f_active = 0; f_wait = 0; m_valid = 0;
                    e_req = 0; e_err = 1; e_ready = 1; e_instr = NOP_W;
                end
            end
        end else if (!hit) begin
            f_active = 1; f_hi = 0; f_tag = t; f_wait = 0;
            e_req = 1; e_addr = {t, 2'b00};
        end
        if (e_ready) e_chk_instr = 1'b1;
    endtask

    always @(negedge clk) begin
        if (pred_ok && model_on) begin
            chk("model_inst_ready", {31'd0, inst_ready}, {31'd0, e_ready});
            if (e_chk_instr) chk("model_instruction", instruction, e_instr);
            chk("model_mem_req", {31'd0, mem_req}, {31'd0, e_req});
            if (e_req) chk("model_mem_addr", mem_addr, e_addr);
            chk("model_fetch_err", {31'd0, fetch_err}, {31'd0, e_err});
        end
        if (mem_req && mem_ack) beats.push_back(mem_addr);
        if (inst_ready && instruction == mem_word(30'h40)) bad100++;
        predict();
        pred_ok = 1'b1;
    end

    initial begin
        step(3);
        chk("rst_instruction", instruction, NOP_W);
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
`ifdef INST_FETCH_PREFETCH_EN
        model_on = 1'b0;
        beats.delete();
        rst = 1'b0;
        step(3);
        chk("pf_word0_ready", {31'd0, inst_ready}, 32'd1);
        chk("pf_word0_data", instruction, 32'h0050_0093);
        chk("pf_lo_req", {31'd0, mem_req}, 32'd1);
        chk("pf_lo_addr", mem_addr, 32'h4);
        step(2);
        chk("pf_idle_req", {31'd0, mem_req}, 32'd0);
        chk("pf_beat_count", beats.size(), 32'd4);
        chk("pf_beat2", beats[2], 32'h4);
        chk("pf_beat3", beats[3], 32'h6);
        inst_addr = 32'h4;
        step(1);
        chk("pf_hit_ready", {31'd0, inst_ready}, 32'd1);
        chk("pf_hit_data", instruction, mem_word(30'd1));
        step(2);
        chk("pf_no_demand_beats", beats.size(), 32'd4);
        chk("pf_hit_held", {31'd0, inst_ready}, 32'd1);
`else
        // zero-wait fetch of word 0
        beats.delete();
        rst = 1'b0;
        step(2);
        chk("t1_ready_early", {31'd0, inst_ready}, 32'd0);
        step(1);
        chk("t1_ready", {31'd0, inst_ready}, 32'd1);
        chk("t1_data", instruction, 32'h0050_0093);
        chk("t1_beat_count", beats.size(), 32'd2);
        chk("t1_beat0", beats[0], 32'h0);
        chk("t1_beat1", beats[1], 32'h2);
        // held address keeps hitting
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t2_ready_held", {31'd0, inst_ready}, 32'd1);
            chk("t2_no_req", {31'd0, mem_req}, 32'd0);
        end
        // three wait cycles per beat
        ack_delay = 3;
        inst_addr = 32'h8;
        step(2);
        chk("t3_req_waiting", {31'd0, mem_req}, 32'd1);
        chk("t3_addr_waiting", mem_addr, 32'h8);
        step(6);
        chk("t3_ready_early", {31'd0, inst_ready}, 32'd0);
        step(1);
        chk("t3_ready", {31'd0, inst_ready}, 32'd1);
        chk("t3_data", instruction, mem_word(30'd2));
        // redirect in the lo-ack cycle
        ack_delay = 0;
        beats.delete();
        inst_addr = 32'h100;
        step(1);
        inst_addr = 32'h200;
        step(5);
        chk("t4_ready", {31'd0, inst_ready}, 32'd1);
        chk("t4_data", instruction, mem_word(30'h80));
        chk("t4_beat_count", beats.size(), 32'd4);
        chk("t4_beat0", beats[0], 32'h100);
        chk("t4_beat1", beats[1], 32'h102);
        chk("t4_beat2", beats[2], 32'h200);
        chk("t4_beat3", beats[3], 32'h202);
        chk("t4_stale_word_delivered", bad100, 32'd0);
        // hung bus
        ack_en = 1'b0;
        inst_addr = 32'h300;
        step(8);
        chk("t5_req_last_wait", {31'd0, mem_req}, 32'd1);
        chk("t5_err_before", {31'd0, fetch_err}, 32'd0);
        step(1);
        chk("t5_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("t5_err_set", {31'd0, fetch_err}, 32'd1);
        chk("t5_nop_ready", {31'd0, inst_ready}, 32'd1);
        chk("t5_nop_data", instruction, NOP_W);
        step(1);
        chk("t5_nop_one_cycle", {31'd0, inst_ready}, 32'd0);
        chk("t5_err_sticky", {31'd0, fetch_err}, 32'd1);
        // reset in the middle of the retried fetch
        rst = 1'b1;
        step(1);
        chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t5_rst_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        inst_addr = 32'h0;
        step(3);
        chk("t5_refetch_ready", {31'd0, inst_ready}, 32'd1);
        chk("t5_refetch_data", instruction, 32'h0050_0093);
`endif
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
